// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, Hamming(7,4) bit
// positions and the default bit period, used by the TX and RX paths.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // code[i] carries Hamming position i+1
  localparam int HAM_P1 = 0;
  localparam int HAM_P2 = 1;
  localparam int HAM_D0 = 2;
  localparam int HAM_P4 = 3;
  localparam int HAM_D1 = 4;
  localparam int HAM_D2 = 5;
  localparam int HAM_D3 = 6;

endpackage

// File: rtl/hamming_decoder_74.sv
// Hamming(7,4) syndrome and nibble extraction (combinational).
// Ports: code[6:0] in; nibble[3:0], syndrome[2:0] out.
// With HAMMING_CORRECT_EN defined, single-bit errors are corrected;
// otherwise the nibble is passed through uncorrected (detect-only).
module hamming_decoder_74
  import uart_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] nibble,
  output logic [2:0] syndrome
);

  logic [6:0] fixed;

  always_comb begin
    syndrome[0] = code[HAM_P1] ^ code[HAM_D0]
                ^ code[HAM_D1] ^ code[HAM_D3];
    syndrome[1] = code[HAM_P2] ^ code[HAM_D0]
                ^ code[HAM_D2] ^ code[HAM_D3];
    syndrome[2] = code[HAM_P4] ^ code[HAM_D1]
                ^ code[HAM_D2] ^ code[HAM_D3];
    fixed = code;
`ifdef HAMMING_CORRECT_EN
    // syndrome names the 1-based position of the flipped bit
    if (syndrome != 3'd0) begin
      fixed = code ^ (7'd1 << (syndrome - 3'd1));
    end
`endif
    nibble = {fixed[HAM_D3], fixed[HAM_D2],
              fixed[HAM_D1], fixed[HAM_D0]};
  end

endmodule

// File: rtl/uart_hamming_rx.sv
// UART 8N1 receiver carrying a Hamming(7,4) codeword in bits 6:0.
// Ports: clk, rst_n (async low), rx (async serial, idle high);
// data_out[3:0], data_valid (pulse), err_flag, frame_err (pulse),
// rx_busy. Optional: `define HAMMING_CORRECT_EN for correction.
module uart_hamming_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       err_flag,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  uart_state_e   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_s1;
  logic          rx_s2;
  logic [3:0]    nibble;
  logic [2:0]    syndrome;

  hamming_decoder_74 u_dec (
    .code     (shreg[6:0]),
    .nibble   (nibble),
    .syndrome (syndrome)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      err_flag   <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s2) begin
            state   <= ST_START;
            rx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s2) begin
              state <= ST_DATA;
            end else begin
              // too short to be a start bit
              state   <= ST_IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
            if (rx_s2 && !shreg[7]) begin
              data_out   <= nibble;
              err_flag   <= |syndrome;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hamming_rx.sv
// Directed self-checking bench for uart_hamming_rx (CLKS_PER_BIT=16).
module tb_uart_hamming_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [3:0] data_out;
  logic       data_valid;
  logic       err_flag;
  logic       frame_err;
  logic       rx_busy;

  int n_chk;
  int n_fail;

  int dv_cnt;
  int fe_cnt;
  int both_cnt;
  logic [3:0] cap_do [0:63];
  logic       cap_er [0:63];

  uart_hamming_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .err_flag   (err_flag),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      cap_do[dv_cnt % 64] = data_out;
      cap_er[dv_cnt % 64] = err_flag;
      dv_cnt = dv_cnt + 1;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (data_valid && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop;
    cycles(CPB);
    rx = 1'b1;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx = 1'b1;
    #3;
    n_chk++;
    if ({data_out, data_valid, err_flag, frame_err, rx_busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {data_out, data_valid, err_flag, frame_err, rx_busy});
    end
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    n_chk++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got %b expected 0", rx_busy);
    end
  endtask

  task automatic test_basic;
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send(8'h55, 1'b1);
    cycles(4);
    n_chk++;
    if (dv_cnt - dv0 !== 1) begin
      n_fail++;
      $display("FAIL basic_dv_count: got %0d expected 1", dv_cnt - dv0);
    end
    n_chk++;
    if (fe_cnt - fe0 !== 0) begin
      n_fail++;
      $display("FAIL basic_fe_count: got %0d expected 0", fe_cnt - fe0);
    end
    n_chk++;
    if (data_out !== 4'hB) begin
      n_fail++;
      $display("FAIL basic_data: got %h expected b", data_out);
    end
    n_chk++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_err: got %b expected 0", err_flag);
    end
    n_chk++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: got %b expected 0", rx_busy);
    end
  endtask

  task automatic test_corrupt;
    int dv0;
    logic [3:0] exp_d;
`ifdef HAMMING_CORRECT_EN
    exp_d = 4'hB;
`else
    exp_d = 4'h9;
`endif
    dv0 = dv_cnt;
    send(8'h45, 1'b1);
    cycles(4);
    n_chk++;
    if (dv_cnt - dv0 !== 1) begin
      n_fail++;
      $display("FAIL corrupt_dv_count: got %0d expected 1", dv_cnt - dv0);
    end
    n_chk++;
    if (data_out !== exp_d) begin
      n_fail++;
      $display("FAIL corrupt_data: got %h expected %h", data_out, exp_d);
    end
    n_chk++;
    if (err_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL corrupt_err: got %b expected 1", err_flag);
    end
  endtask

  task automatic test_back_to_back;
    int dv0;
    dv0 = dv_cnt;
    send(8'h00, 1'b1);
    send(8'h7F, 1'b1);
    cycles(4);
    n_chk++;
    if (dv_cnt - dv0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_dv_count: got %0d expected 2", dv_cnt - dv0);
    end else begin
      n_chk++;
      if (cap_do[dv0 % 64] !== 4'h0) begin
        n_fail++;
        $display("FAIL b2b_data0: got %h expected 0", cap_do[dv0 % 64]);
      end
      n_chk++;
      if (cap_er[dv0 % 64] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_err0: got %b expected 0", cap_er[dv0 % 64]);
      end
      n_chk++;
      if (cap_do[(dv0 + 1) % 64] !== 4'hF) begin
        n_fail++;
        $display("FAIL b2b_data1: got %h expected f",
                 cap_do[(dv0 + 1) % 64]);
      end
      n_chk++;
      if (cap_er[(dv0 + 1) % 64] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_err1: got %b expected 0",
                 cap_er[(dv0 + 1) % 64]);
      end
    end
  endtask

  task automatic test_frame_err(input logic [7:0] b, input logic stop,
                                input string nm);
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send(b, stop);
    cycles(3 * CPB);
    n_chk++;
    if (fe_cnt - fe0 !== 1) begin
      n_fail++;
      $display("FAIL %s_fe_count: got %0d expected 1", nm, fe_cnt - fe0);
    end
    n_chk++;
    if (dv_cnt - dv0 !== 0) begin
      n_fail++;
      $display("FAIL %s_dv_count: got %0d expected 0", nm, dv_cnt - dv0);
    end
    n_chk++;
    if (data_out !== 4'hF) begin
      n_fail++;
      $display("FAIL %s_data_held: got %h expected f", nm, data_out);
    end
    n_chk++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_err_held: got %b expected 0", nm, err_flag);
    end
  endtask

  task automatic test_glitch;
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    cycles(5);
    rx = 1'b1;
    cycles(3 * CPB);
    n_chk++;
    if ((dv_cnt - dv0) + (fe_cnt - fe0) !== 0) begin
      n_fail++;
      $display("FAIL glitch_pulses: got %0d expected 0",
               (dv_cnt - dv0) + (fe_cnt - fe0));
    end
    n_chk++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy: got %b expected 0", rx_busy);
    end
  endtask

  task automatic test_midframe_reset;
    int dv0, fe0;
    logic [7:0] b;
    b = 8'h55;
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = b[3];
    cycles(CPB / 2);
    n_chk++;
    if (rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy_before: got %b expected 1", rx_busy);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    #2;
    n_chk++;
    if ({data_out, data_valid, err_flag, frame_err, rx_busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %b expected 00000000",
               {data_out, data_valid, err_flag, frame_err, rx_busy});
    end
    cycles(4);
    rst_n = 1'b1;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    cycles(12 * CPB);
    n_chk++;
    if ((dv_cnt - dv0) + (fe_cnt - fe0) !== 0) begin
      n_fail++;
      $display("FAIL midrst_stale_pulse: got %0d expected 0",
               (dv_cnt - dv0) + (fe_cnt - fe0));
    end
    send(8'h55, 1'b1);
    cycles(4);
    n_chk++;
    if (dv_cnt - dv0 !== 1) begin
      n_fail++;
      $display("FAIL midrst_dv_count: got %0d expected 1", dv_cnt - dv0);
    end
    n_chk++;
    if (data_out !== 4'hB) begin
      n_fail++;
      $display("FAIL midrst_data: got %h expected b", data_out);
    end
    n_chk++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_err: got %b expected 0", err_flag);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    dv_cnt = 0;
    fe_cnt = 0;
    both_cnt = 0;
    rx = 1'b1;
    rst_n = 1'b0;
    test_reset;
    test_basic;
    test_corrupt;
    test_back_to_back;
    test_frame_err(8'h55, 1'b0, "stop0");
    test_frame_err(8'hD5, 1'b1, "bit7");
    test_glitch;
    test_midframe_reset;
    n_chk++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL dv_fe_overlap: got %0d expected 0", both_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_hamming_rx.md
UART_HAMMING_RX -- requirements
Module: uart_hamming_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 16, clock cycles per UART bit; legal range is even values >= 4.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: rx  input  1  asynchronous UART serial line; idles high.
REQ-005 SHALL have port: data_out  output  4  decoded nibble, held until the next accepted frame.
REQ-006 SHALL have port: data_valid  output  1  one-cycle pulse when data_out updates.
REQ-007 SHALL have port: err_flag  output  1  nonzero syndrome on the last accepted frame; updated together with data_valid.
REQ-008 SHALL have port: frame_err  output  1  one-cycle pulse for a bad stop bit or bit7 = 1.
REQ-009 SHALL have port: rx_busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value.
REQ-011 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-012 SHALL move IDLE->START on synchronized rx = 0.
REQ-013 SHALL, in START, sample after CLKS_PER_BIT/2 cycles: rx = 0 -> DATA; rx = 1 -> IDLE (glitch, no output).
REQ-014 SHALL, in DATA, sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into an 8-bit shift register; after bit 7 -> STOP.
REQ-015 SHALL, in STOP, sample after CLKS_PER_BIT cycles, then go to IDLE the next cycle.
REQ-016 SHALL, if stop = 1 and bit7 = 0, pulse data_valid exactly one cycle after the stop sample.
REQ-017 SHALL otherwise pulse frame_err one cycle after the stop sample, with no data_valid and data_out/err_flag unchanged.
REQ-018 SHALL use Hamming mapping code[i] = position i+1: p1, p2, d0, p4, d1, d2, d3 for code[0..6]; the nibble is {code[6], code[5], code[4], code[2]}.
REQ-019 SHALL compute the syndrome as s = {s4, s2, s1}, with s1 = ^positions{1,3,5,7}, s2 = ^{2,3,6,7}, s4 = ^{4,5,6,7}.
REQ-020 SHALL set err_flag = (s != 0).
REQ-021 SHALL accept a new start bit in IDLE on the cycle immediately following the return from STOP; back-to-back frames SHALL be received without loss.
REQ-022 SHALL never assert data_valid and frame_err in the same cycle.

Reset
REQ-023 SHALL, on rst_n low, immediately force: state IDLE, counters 0, shift register 0, synchronizer flops 1, data_out 0, data_valid 0, err_flag 0, frame_err 0, rx_busy 0.
REQ-024 SHALL abandon a frame in progress when reset occurs mid-frame and produce no pulse for it after reset release.

Configuration
REQ-025 SHALL, with HAMMING_CORRECT_EN defined, invert code bit (s-1) before nibble extraction when s != 0, so that single-bit errors are corrected.
REQ-026 SHALL, without HAMMING_CORRECT_EN, output the nibble uncorrected, with err_flag still reporting a nonzero syndrome (detect-only).

Structure
REQ-027 SHALL place the FSM state encodings, the Hamming position constants and the CLKS_PER_BIT default in a shared uart_pkg used by both the transmit and receive paths.
REQ-028 SHALL place the syndrome computation and correction in one combinational sub-module, hamming_decoder_74 (in: code[6:0]; out: nibble[3:0], syndrome[2:0]), instantiated once.

Verification
REQ-029 SHALL cover: frame byte 0x55 (nibble 0xB encoded), CLKS_PER_BIT = 16 -> data_out = 0xB, err_flag = 0, one data_valid pulse, rx_busy low afterwards.
REQ-030 SHALL cover: byte 0x45 (0x55 with code[4] flipped) -> with HAMMING_CORRECT_EN: data_out = 0xB, err_flag = 1; without it: data_out = 0x9, err_flag = 1.
REQ-031 SHALL cover: bytes 0x00 then 0x7F sent back-to-back with no idle gap -> two data_valid pulses, data_out = 0x0 then 0xF, err_flag = 0 both times.
REQ-032 SHALL cover: byte 0x55 with stop bit driven 0 -> frame_err pulse, no data_valid, data_out keeps its prior value; the same applies to byte 0xD5 (bit7 = 1).
REQ-033 SHALL cover: a 5-cycle low glitch on rx -> return to IDLE, no data_valid and no frame_err.
REQ-034 SHALL cover: rst_n pulsed low during DATA bit 3, then a clean 0x55 frame -> all outputs 0 during reset, then a single valid 0xB.
